// File: rtl/cycle_trainer_core.sv
// Exercise-bike console controller: ADC-to-Celsius conversion, button debounce,
// cadence strobes and an acknowledgeable over-temperature alarm.
module cycle_trainer_core #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned TEMP_LIMIT      = 40,
   parameter int unsigned TEMP_HYST       = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] adc_input,
   input  logic        status,
   input  logic        pulse_button,
   input  logic        buttons,
   output logic [7:0]  temperature,
   output logic        led,
   output logic        pulses
);

   localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0] LimitLvl = 8'(TEMP_LIMIT);
   localparam logic [7:0] ClearLvl = 8'(TEMP_LIMIT - TEMP_HYST);

   typedef enum logic [1:0] {
      StNormal,
      StAlarm,
      StAcked
   } alarm_state_e;

   // Bit 0 is the cadence button, bit 1 the alarm-acknowledge button.
   logic [1:0]      btn_raw;
   logic [1:0]      sync1_q, sync2_q;
   logic [1:0]      stable_q, stable_d;
   logic [1:0]      stable_prev_q;
   logic [CntW-1:0] cnt_q [2];
   logic [CntW-1:0] cnt_d [2];
   logic [1:0]      press;

   logic [7:0]      temperature_q, temperature_d;
   logic            pulses_q;
   logic            led_q;
   alarm_state_e    state_q;

   logic            temp_high;
   logic            temp_clear;

   assign btn_raw = {buttons, pulse_button};
   assign press   = stable_q & ~stable_prev_q;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         stable_d[i] = stable_q[i];
         cnt_d[i]    = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CntMax) begin
               stable_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q       <= '0;
         sync2_q       <= '0;
         stable_q      <= '0;
         stable_prev_q <= '0;
         cnt_q[0]      <= '0;
         cnt_q[1]      <= '0;
      end else begin
         sync1_q       <= btn_raw;
         sync2_q       <= sync1_q;
         stable_q      <= stable_d;
         stable_prev_q <= stable_q;
         cnt_q[0]      <= cnt_d[0];
         cnt_q[1]      <= cnt_d[1];
      end
   end

   // (adc * 100) >> 12 tops out at 99 for a 12-bit sample, so 19 bits suffice.
   always_comb begin
      temperature_d = temperature_q;
      if (status) begin
         temperature_d = 8'((19'(adc_input) * 19'd100) >> 12);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         temperature_q <= '0;
         pulses_q      <= 1'b0;
      end else begin
         temperature_q <= temperature_d;
         pulses_q      <= press[0] & status;
      end
   end

   assign temp_high  = (temperature_q >= LimitLvl);
   assign temp_clear = (temperature_q < ClearLvl);

   // Clearing wins over an acknowledge arriving in the same cycle.
   always_ff @(posedge clock) begin
      if (reset || !status) begin
         state_q <= StNormal;
         led_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StNormal: begin
               if (temp_high) begin
                  state_q <= StAlarm;
                  led_q   <= 1'b1;
               end
            end
            StAlarm: begin
               if (temp_clear) begin
                  state_q <= StNormal;
                  led_q   <= 1'b0;
               end else if (press[1]) begin
                  state_q <= StAcked;
                  led_q   <= 1'b0;
               end
            end
            StAcked: begin
               if (temp_clear) begin
                  state_q <= StNormal;
               end
               led_q <= 1'b0;
            end
            default: begin
               state_q <= StNormal;
               led_q   <= 1'b0;
            end
         endcase
      end
   end

   assign temperature = temperature_q;
   assign led         = led_q;
   assign pulses      = pulses_q;

endmodule

// File: tb/tb_cycle_trainer_core.sv
// Directed self-checking bench for cycle_trainer_core with the default parameters.
module tb_cycle_trainer_core;

   logic        clock;
   logic        reset;
   logic [11:0] adc_input;
   logic        status;
   logic        pulse_button;
   logic        buttons;
   logic [7:0]  temperature;
   logic        led;
   logic        pulses;

   int n_chk  = 0;
   int n_fail = 0;
   int hits;
   int first_hit;

   cycle_trainer_core #(
      .DEBOUNCE_CYCLES(4),
      .TEMP_LIMIT     (40),
      .TEMP_HYST      (2)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .adc_input   (adc_input),
      .status      (status),
      .pulse_button(pulse_button),
      .buttons     (buttons),
      .temperature (temperature),
      .led         (led),
      .pulses      (pulses)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one rising edge and settle 1ns past it.
   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Tick n times, counting pulses strobes and the 1-based tick of the first one.
   task automatic watch_pulses(input int n);
      for (int k = 1; k <= n; k++) begin
         tick();
         if (pulses === 1'b1) begin
            if (hits == 0) first_hit = k;
            hits++;
         end
      end
   endtask

   initial begin
      reset        = 1'b1;
      adc_input    = 12'd1234;
      status       = 1'b1;
      pulse_button = 1'b1;
      buttons      = 1'b1;
      tick();
      chk("reset_temp", temperature, 8'd0);
      chk("reset_led", {7'd0, led}, 8'd0);
      chk("reset_pulses", {7'd0, pulses}, 8'd0);
      tick();
      chk("reset_temp2", temperature, 8'd0);

      reset        = 1'b0;
      pulse_button = 1'b0;
      buttons      = 1'b0;
      tick(10);

      // Conversion
      adc_input = 12'd819;
      tick();
      chk("conv_819", temperature, 8'd19);
      adc_input = 12'd0;
      tick();
      chk("conv_0", temperature, 8'd0);
      status    = 1'b0;
      adc_input = 12'd4095;
      tick();
      chk("conv_hold", temperature, 8'd0);
      status = 1'b1;
      tick();
      chk("conv_4095", temperature, 8'd99);
      adc_input = 12'd0;
      tick();
      chk("conv_back_0", temperature, 8'd0);
      chk("brief_alarm_led", {7'd0, led}, 8'd1);
      tick();
      chk("brief_alarm_clear", {7'd0, led}, 8'd0);
      tick(3);

      // Single strobe for a long press, seventh edge after the press
      pulse_button = 1'b1;
      hits = 0; first_hit = 0;
      watch_pulses(20);
      chk("press_count", 8'(hits), 8'd1);
      chk("press_edge", 8'(first_hit), 8'd7);
      pulse_button = 1'b0;
      hits = 0;
      watch_pulses(10);
      chk("release_no_strobe", 8'(hits), 8'd0);

      // Two-cycle glitch is rejected
      pulse_button = 1'b1;
      tick(2);
      pulse_button = 1'b0;
      hits = 0;
      watch_pulses(12);
      chk("glitch_no_strobe", 8'(hits), 8'd0);

      // No strobe while idle
      status       = 1'b0;
      pulse_button = 1'b1;
      hits = 0;
      watch_pulses(12);
      pulse_button = 1'b0;
      watch_pulses(10);
      chk("idle_no_strobe", 8'(hits), 8'd0);
      status = 1'b1;
      tick();

      // Alarm raise and acknowledge
      adc_input = 12'd1720;
      tick();
      chk("conv_1720", temperature, 8'd41);
      chk("alarm_not_yet", {7'd0, led}, 8'd0);
      tick();
      chk("alarm_led_on", {7'd0, led}, 8'd1);
      buttons = 1'b1;
      tick(6);
      chk("ack_pending", {7'd0, led}, 8'd1);
      tick();
      chk("ack_led_off", {7'd0, led}, 8'd0);
      tick(3);
      buttons = 1'b0;
      tick(10);
      chk("acked_stays_off", {7'd0, led}, 8'd0);

      // Hysteresis: 38 keeps ACKED, 35 returns to NORMAL
      adc_input = 12'd1573;
      tick();
      chk("conv_1573", temperature, 8'd38);
      tick();
      adc_input = 12'd1720;
      tick(2);
      chk("acked_38_then_41", {7'd0, led}, 8'd0);
      adc_input = 12'd1474;
      tick();
      chk("conv_1474", temperature, 8'd35);
      tick();
      chk("normal_35", {7'd0, led}, 8'd0);
      adc_input = 12'd1720;
      tick(2);
      chk("realarm_led_on", {7'd0, led}, 8'd1);

      // Idle overrides the alarm; temperature holds
      status = 1'b0;
      tick();
      chk("override_led_off", {7'd0, led}, 8'd0);
      chk("override_temp_hold", temperature, 8'd41);
      adc_input = 12'd0;
      status    = 1'b1;
      tick(3);

      // Reset one edge before the strobe would appear
      pulse_button = 1'b1;
      hits = 0;
      watch_pulses(6);
      reset        = 1'b1;
      pulse_button = 1'b0;
      watch_pulses(2);
      reset = 1'b0;
      watch_pulses(12);
      chk("reset_mid_press", 8'(hits), 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
